// File: rtl/riscv_pkg.sv
// Shared definitions for the pipelined RISC-V core: opcodes used by the
// memory stage and the memory-stage controller state encoding.
package riscv_pkg;

  localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
  localparam logic [6:0] OPCODE_REG_REG = 7'b0110011;
  localparam logic [6:0] OPCODE_REG_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI     = 7'b0110111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R
  } mem_state_t;

  // True for the two opcodes that touch the data-memory bus.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OPCODE_LOAD) || (op == OPCODE_STORE);
  endfunction

endpackage

// File: rtl/execute_memory_if.sv
// Execute-to-memory pipeline channel with a valid/ready handshake.
interface execute_memory_if #(
  parameter int N = 32
);
  logic         valid;
  logic         ready;
  logic [N-1:0] alu_result;
  logic [N-1:0] rs2_data;
  logic [6:0]   opcode;
  logic         zero;

  modport execute_out (
    output valid, alu_result, rs2_data, opcode, zero,
    input  ready
  );

  modport memory_in (
    input  valid, alu_result, rs2_data, opcode, zero,
    output ready
  );
endinterface

// File: rtl/memory_writeback_if.sv
// Memory-to-writeback pipeline channel with a valid/ready handshake.
interface memory_writeback_if #(
  parameter int N = 32
);
  logic         valid;
  logic         ready;
  logic [N-1:0] wb_data;
  logic [6:0]   opcode;
  logic         misaligned;
  logic         bus_err;

  modport memory_out (
    output valid, wb_data, opcode, misaligned, bus_err,
    input  ready
  );

  modport writeback_in (
    input  valid, wb_data, opcode, misaligned, bus_err,
    output ready
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: accepts execute results, performs aligned word loads/stores
// on a single-outstanding request/grant/response bus, and hands completed
// results to writeback through a registered valid/ready output.
// DMEM_TIMEOUT must be at least 2.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int N            = 32,
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  execute_memory_if.memory_in    em_if,
  memory_writeback_if.memory_out mw_if,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [N-1:0]           dmem_addr,
  output logic [N-1:0]           dmem_wdata,
  output logic [3:0]             dmem_be,
  input  logic                   dmem_gnt,
  input  logic                   dmem_rvalid,
  input  logic [N-1:0]           dmem_rdata
);

  localparam int              CW       = $clog2(DMEM_TIMEOUT) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DMEM_TIMEOUT - 1);

  mem_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [6:0]    op_q, op_d;

  logic          out_valid_q;
  logic [N-1:0]  out_data_q;
  logic [6:0]    out_op_q;
  logic          out_mis_q;
  logic          out_err_q;

  logic          res_load;
  logic [N-1:0]  res_data;
  logic [6:0]    res_op;
  logic          res_mis;
  logic          res_err;

  logic          em_ready;
  logic          unused_zero;

  // The branch-compare flag travels with the channel but the memory stage has no use for it.
  assign unused_zero = em_if.zero;

  // A new op is taken only when the bus is idle and the output slot is free or draining now.
  assign em_ready    = (state_q == IDLE) && (!out_valid_q || mw_if.ready);
  assign em_if.ready = em_ready;

  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[N-1:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_be    = 4'hF;

  assign mw_if.valid      = out_valid_q;
  assign mw_if.wb_data    = out_data_q;
  assign mw_if.opcode     = out_op_q;
  assign mw_if.misaligned = out_mis_q;
  assign mw_if.bus_err    = out_err_q;

  // Bus controller state, captured access fields and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; also decides when a result is ready to load into the output slot.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    op_d     = op_q;
    res_load = 1'b0;
    res_data = '0;
    res_op   = op_q;
    res_mis  = 1'b0;
    res_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (em_if.valid && em_ready) begin
          if (is_mem_op(em_if.opcode)) begin
            if (em_if.alu_result[1:0] != 2'b00) begin
              res_load = 1'b1;
              res_data = em_if.alu_result;
              res_op   = em_if.opcode;
              res_mis  = 1'b1;
            end else begin
              addr_d  = em_if.alu_result;
              wdata_d = em_if.rs2_data;
              we_d    = (em_if.opcode == OPCODE_STORE);
              op_d    = em_if.opcode;
              cnt_d   = '0;
              state_d = REQ;
            end
          end else begin
            res_load = 1'b1;
            res_data = em_if.alu_result;
            res_op   = em_if.opcode;
          end
        end
      end

      REQ: begin
        if (dmem_gnt) begin
          if (we_q) begin
            res_load = 1'b1;
            res_data = addr_q;
            state_d  = IDLE;
          end else if (dmem_rvalid) begin
            res_load = 1'b1;
            res_data = dmem_rdata;
            state_d  = IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = WAIT_R;
          end
        end else if (cnt_q >= CNT_LAST) begin
          res_load = 1'b1;
          res_err  = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_R: begin
        if (dmem_rvalid) begin
          res_load = 1'b1;
          res_data = dmem_rdata;
          state_d  = IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          res_load = 1'b1;
          res_err  = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output slot: a new result overrides a same-cycle drain, otherwise a handshake empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_op_q    <= '0;
      out_mis_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (res_load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res_data;
      out_op_q    <= res_op;
      out_mis_q   <= res_mis;
      out_err_q   <= res_err;
    end else if (out_valid_q && mw_if.ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
